// File: rtl/multdiv_pkg.sv
// Shared definitions for the multdiv unit: FSM state encoding, default
// datapath widths and the radix-2 Booth recoding constants.
package multdiv_pkg;

    // Default operand/result width and iteration counter width.
    localparam int DEF_WIDTH   = 32;
    localparam int DEF_COUNT_W = 6;

    // Sequencer states shared by the multiply and divide engines.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Booth pair {Q[0], q_m1}: 01 adds the multiplicand, 10 subtracts it.
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the multiplicand
// into the accumulator, then an arithmetic right shift of {acc, Q, q_m1}.
module booth_step
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] q,
    input  logic             q_m1,
    input  logic [WIDTH:0]   m,
    output logic [WIDTH:0]   acc_next,
    output logic [WIDTH-1:0] q_next,
    output logic             q_m1_next
);

    logic [1:0]     code;
    logic [WIDTH:0] addend;
    logic           cin;
    logic [WIDTH:0] sum;

    assign code = {q[0], q_m1};

    // Select the addend: +M, -M (as ~M with carry-in 1) or nothing.
    always_comb begin
        addend = '0;
        cin    = 1'b0;
        case (code)
            BOOTH_ADD: addend = m;
            BOOTH_SUB: begin
                addend = ~m;
                cin    = 1'b1;
            end
            default: ;
        endcase
    end

    cla_adder #(.N(WIDTH + 1)) u_add (
        .a   (acc),
        .b   (addend),
        .cin (cin),
        .sum (sum)
    );

    // Arithmetic shift right by one, sign-filling from the accumulator MSB.
    assign acc_next  = {sum[WIDTH], sum[WIDTH:1]};
    assign q_next    = {sum[0], q[WIDTH-1:1]};
    assign q_m1_next = q[0];

endmodule

// File: rtl/cla_adder.sv
// Carry-lookahead adder built from 4-bit lookahead groups; the carry into
// each bit is formed from the group generate/propagate and the group carry-in.
module cla_adder #(
    parameter int N = 33
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum
);

    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N-1:0] c;

    // Per-bit generate/propagate and group-lookahead carry formation.
    always_comb begin
        logic grp_g;
        logic grp_p;
        logic grp_c;
        g     = a & b;
        p     = a ^ b;
        c     = '0;
        c[0]  = cin;
        grp_g = 1'b0;
        grp_p = 1'b1;
        grp_c = cin;
        for (int i = 0; i < N - 1; i++) begin
            if (i % 4 == 0) begin
                grp_g = 1'b0;
                grp_p = 1'b1;
                grp_c = c[i];
            end
            grp_g    = g[i] | (p[i] & grp_g);
            grp_p    = grp_p & p[i];
            c[i + 1] = grp_g | (grp_p & grp_c);
        end
    end

    assign sum = p ^ c;

endmodule

// File: rtl/mult_booth_seq.sv
// Iterative signed radix-2 Booth multiplier: one step per clock, fixed
// latency of WIDTH steps, low WIDTH bits of the product plus overflow flag.
//
// Handshake: ctrl_mult is a start request accepted only in IDLE or DONE;
// while busy is high it is ignored (no queueing). data_resultRDY is a
// one-cycle valid pulse with no back-pressure; data_result and
// data_exception are stable from that pulse until the next result lands.
module mult_booth_seq
    import multdiv_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int COUNT_W = DEF_COUNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_mult,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam logic [COUNT_W-1:0] LAST_STEP = COUNT_W'(WIDTH - 1);

    // Architectural state; 'state' is the FSM register checkers bind to.
    state_t             state;
    logic [COUNT_W-1:0] count;
    logic [WIDTH:0]     acc;
    logic [WIDTH-1:0]   q_reg;
    logic               q_m1;
    logic [WIDTH:0]     m_reg;

    logic [WIDTH:0]     acc_next;
    logic [WIDTH-1:0]   q_next;
    logic               q_m1_next;

    logic [2*WIDTH-1:0] product;
    logic [WIDTH:0]     prod_hi;
    logic               overflow;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc       (acc),
        .q         (q_reg),
        .q_m1      (q_m1),
        .m         (m_reg),
        .acc_next  (acc_next),
        .q_next    (q_next),
        .q_m1_next (q_m1_next)
    );

    // The product fits in WIDTH signed bits only if its upper WIDTH+1 bits
    // are a pure sign extension (all zeros or all ones).
    assign product  = {acc_next[WIDTH-1:0], q_next};
    assign prod_hi  = product[2*WIDTH-1:WIDTH-1];
    assign overflow = ~((&prod_hi) | (~|prod_hi));

    // Sequencer, datapath registers and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            count          <= '0;
            acc            <= '0;
            q_reg          <= '0;
            q_m1           <= 1'b0;
            m_reg          <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    data_resultRDY <= 1'b0;
                    if (ctrl_mult) begin
                        m_reg <= {data_operandA[WIDTH-1], data_operandA};
                        acc   <= '0;
                        q_reg <= data_operandB;
                        q_m1  <= 1'b0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    q_reg <= q_next;
                    q_m1  <= q_m1_next;
                    count <= count + COUNT_W'(1);
                    if (count == LAST_STEP) begin
                        data_result    <= product[WIDTH-1:0];
                        data_exception <= overflow;
                        data_resultRDY <= 1'b1;
                        busy           <= 1'b0;
                        state          <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_booth_seq.sv
// Bench for mult_booth_seq: directed cases plus randomized operands, with a
// scoreboard fed by the driver and drained by a monitor on each ready pulse.
module tb_mult_booth_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         ctrl_mult;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [W-1:0] data_result;
    logic         data_exception;
    logic         data_resultRDY;
    logic         busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Expected {exception, result} and the cycle at which the pulse is due.
    logic [W:0] exp_q[$];
    int         exp_t_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // Count rising edges so latency can be checked against the start edge.
    always @(posedge clk) cyc <= cyc + 1;

    mult_booth_seq #(.WIDTH(W), .COUNT_W(6)) dut (
        .clock          (clk),
        .reset          (rst),
        .ctrl_mult      (ctrl_mult),
        .data_operandA  (op_a),
        .data_operandB  (op_b),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: full signed product by plain arithmetic, then range test.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        longint      pa;
        longint      pb;
        longint      p;
        longint      lim;
        logic [63:0] pu;
        logic        exc;
        pa  = longint'($signed(a));
        pb  = longint'($signed(b));
        p   = pa * pb;
        lim = longint'(1) <<< (W - 1);
        exc = (p >= lim) || (p < -lim);
        pu  = p;
        return {exc, pu[W-1:0]};
    endfunction

    // ---------------- driver tasks ----------------
    // Called just after a falling edge; the start is sampled on the next rise.
    task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input bit accept);
        op_a      = a;
        op_b      = b;
        ctrl_mult = 1'b1;
        if (accept) begin
            exp_q.push_back(model(a, b));
            exp_t_q.push_back(cyc + 1 + W);
        end
        @(negedge clk);
        ctrl_mult = 1'b0;
        op_a      = $urandom;
        op_b      = $urandom;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (exp_q.size() != 0 && n < 200);
        if (exp_q.size() != 0) begin
            check("ready_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
            exp_t_q.delete();
        end
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] special[5];
        special[0] = 32'h0000_0000;
        special[1] = 32'h0000_0001;
        special[2] = 32'hFFFF_FFFF;
        special[3] = 32'h8000_0000;
        special[4] = 32'h7FFF_FFFF;
        case ($urandom_range(0, 3))
            0:       return special[$urandom_range(0, 4)];
            1:       return W'($signed($urandom_range(0, 200)) - 100);
            2:       return W'($urandom_range(0, 65535));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- scoreboard monitor ----------------
    // On every ready pulse pop the oldest expectation and compare value and timing.
    always @(negedge clk) begin
        if (!rst && data_resultRDY) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ready", 64'd1, 64'd0);
            end else begin
                logic [W:0] e;
                int         t;
                e = exp_q.pop_front();
                t = exp_t_q.pop_front();
                check("result", 64'(data_result), 64'(e[W-1:0]));
                check("exception", 64'(data_exception), 64'(e[W]));
                check("latency", 64'(cyc), 64'(t));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] dir_a[8];
        logic [W-1:0] dir_b[8];
        bit           bad_busy;
        bit           bad_hold;

        rst       = 1'b1;
        ctrl_mult = 1'b0;
        op_a      = '0;
        op_b      = '0;

        @(negedge clk);
        check("reset_result", 64'(data_result), 64'd0);
        check("reset_exception", 64'(data_exception), 64'd0);
        check("reset_ready", 64'(data_resultRDY), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 7 x 6 with busy window and result-hold checks.
        drive_start(32'd7, 32'd6, 1'b1);
        bad_busy = 1'b0;
        bad_hold = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (busy !== 1'b1 || data_resultRDY !== 1'b0) bad_busy = 1'b1;
            if (data_result !== '0 || data_exception !== 1'b0) bad_hold = 1'b1;
            @(negedge clk);
        end
        check("busy_window", 64'(bad_busy), 64'd0);
        check("result_hold", 64'(bad_hold), 64'd0);
        check("busy_after_done", 64'(busy), 64'd0);
        wait_done();

        // Directed corner cases.
        dir_a[0] = 32'hFFFF_FFFD; dir_b[0] = 32'd5;
        dir_a[1] = 32'd5;         dir_b[1] = 32'hFFFF_FFFD;
        dir_a[2] = 32'h0001_0000; dir_b[2] = 32'h0001_0000;
        dir_a[3] = 32'h8000_0000; dir_b[3] = 32'hFFFF_FFFF;
        dir_a[4] = 32'h8000_0000; dir_b[4] = 32'd1;
        dir_a[5] = 32'h8000_0000; dir_b[5] = 32'd0;
        dir_a[6] = 32'h8000_0000; dir_b[6] = 32'h8000_0000;
        dir_a[7] = 32'h7FFF_FFFF; dir_b[7] = 32'h7FFF_FFFF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive_start(dir_a[i], dir_b[i], 1'b1);
            wait_done();
        end

        // Start ignored mid-run, then restart in the DONE cycle.
        @(negedge clk);
        drive_start(32'd2, 32'd3, 1'b1);
        repeat (9) @(negedge clk);
        drive_start(32'd9, 32'd9, 1'b0);
        wait_done();
        drive_start(32'd4, 32'd4, 1'b1);
        wait_done();

        // Asynchronous reset during a run aborts it without a result pulse.
        @(negedge clk);
        drive_start(32'd123, 32'd456, 1'b1);
        repeat (14) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_result", 64'(data_result), 64'd0);
        check("abort_exception", 64'(data_exception), 64'd0);
        check("abort_ready", 64'(data_resultRDY), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        exp_q.delete();
        exp_t_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        drive_start(32'd11, 32'd11, 1'b1);
        wait_done();

        // Randomized operands with random idle gaps (gap 0 restarts in DONE).
        for (int i = 0; i < 40; i++) begin
            int gap;
            drive_start(pick_operand(), pick_operand(), 1'b1);
            wait_done();
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_booth_seq.md
Name: mult_booth_seq

Overview:
- Iterative signed radix-2 Booth multiplier; the multiply counterpart of the restoring-division step logic in the multdiv unit.
- Accepts a start pulse and two 32-bit two's-complement operands.
- Performs one Booth step per clock and returns the low 32 bits of the product, an overflow flag and a one-cycle ready pulse.
- Sits beside the divider under the shared multdiv wrapper, which arbitrates ctrl_MULT and ctrl_DIV.

Parameters:
- WIDTH, 32, operand and result width in bits.
- COUNT_W, 6, width of the iteration counter; must satisfy 2^COUNT_W > WIDTH.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- ctrl_mult  in  1  start pulse; sampled on the rising edge of clock.
- data_operandA  in  WIDTH  multiplicand, signed; sampled with ctrl_mult.
- data_operandB  in  WIDTH  multiplier, signed; sampled with ctrl_mult.
- data_result  out  WIDTH  low WIDTH bits of the product; registered.
- data_exception  out  1  set when the signed product does not fit in WIDTH bits; registered.
- data_resultRDY  out  1  one-cycle pulse when data_result and data_exception are valid.
- busy  out  1  high while iterating (state RUN).

Behaviour:
- Reset values: state=IDLE, count=0, acc=0, Q=0, q_m1=0, multiplicand register M=0, data_result=0, data_exception=0, data_resultRDY=0, busy=0.
- Internal registers:
  - acc: WIDTH+1 bits, so that subtracting -2^(WIDTH-1) cannot overflow.
  - Q: WIDTH bits.
  - q_m1: 1 bit.
  - M: WIDTH+1 bits, sign-extended operand A.
- States: IDLE, RUN, DONE.
- IDLE or DONE, ctrl_mult=1 at an edge:
  - M <= sext(A), acc <= 0, Q <= B, q_m1 <= 0, count <= 0.
  - Next state RUN; busy=1; data_resultRDY=0.
  - data_result and data_exception keep their previous values until the new result is written.
- RUN, each edge — one Booth step on {Q[0], q_m1}:
  - 01: acc += M. 10: acc -= M. 00 or 11: no add.
  - Then arithmetic shift right of {acc, Q, q_m1} by 1, sign-filling from acc[WIDTH].
  - count <= count+1.
  - ctrl_mult is ignored in RUN; no restart, no queueing.
- RUN, at the edge that performs step WIDTH (count==WIDTH-1):
  - Let P = {acc[WIDTH-1:0], Q} after the step (2*WIDTH bits).
  - data_result <= P[WIDTH-1:0].
  - data_exception <= 1 unless P[2*WIDTH-1:WIDTH-1] are all equal (all zeros or all ones).
  - State DONE, data_resultRDY=1, busy=0.
- DONE, next edge:
  - data_resultRDY <= 0; state IDLE, unless ctrl_mult=1, which restarts as above.
- Latency: start sampled at edge E0; data_resultRDY is high in the cycle following edge E(WIDTH), i.e. edge 32 for the default width. This is fixed and data-independent.
- Reset asserted mid-operation: immediate return to IDLE and all outputs to reset values. No result pulse is ever produced for the aborted operation.
- Operand inputs are don't-care except at the start edge.
- Any operand value is accepted, including 0 and -2^(WIDTH-1).

Decomposition:
- Shared package (multdiv_pkg) holds:
  - state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - WIDTH and COUNT_W defaults;
  - Booth code constants (BOOTH_ADD=2'b01, BOOTH_SUB=2'b10).
- One combinational sub-module, booth_step:
  - inputs acc, Q, q_m1, M; outputs next acc, Q, q_m1;
  - add/subtract built from the existing cla_adder, with subtract implemented as add of ~M with carry-in 1.
- The top level keeps the FSM, counter, registers and the overflow check.

Test Plan:
- Reset, then A=7, B=6, ctrl_mult pulse at E0 → busy high for cycles 1-32; data_resultRDY high exactly one cycle after E32; data_result=42; data_exception=0.
- A=-3 (0xFFFFFFFD), B=5 → data_result=0xFFFFFFF1 (-15); data_exception=0. Repeat with A=5, B=-3 → identical result.
- A=0x00010000, B=0x00010000 → data_result=0x00000000; data_exception=1. A=0x80000000, B=0xFFFFFFFF → data_result=0x80000000; data_exception=1.
- A=0x80000000, B=1 → data_result=0x80000000; data_exception=0. A=0x80000000, B=0 → data_result=0; data_exception=0.
- Mid-operation start: start A=2, B=3; pulse ctrl_mult with A=9, B=9 at E10 → ignored; ready after E32 with data_result=6. Then back-to-back restart in the DONE cycle with A=4, B=4 → next ready 32 edges later with data_result=16.
- Reset at cycle 15 of a run → all outputs 0 immediately (asynchronous); no ready pulse appears; a fresh 11×11 afterwards yields 121 with normal latency.
